// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble, one bit per cycle).
// Fixed 14-cycle latency per conversion. start is ignored while busy; values above 9999 saturate to 9999 and set ovf.
module bin2bcd_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [13:0] bin_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] bcd_out,
   output logic        ovf
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      state;
   logic [13:0] bin_sr;
   logic [15:0] bcd_wr;
   logic [3:0]  cnt;
   logic        big;
   logic [15:0] bcd_adj;
   logic [15:0] bcd_nxt;

   // Digits >= 5 get +3 so that the following left shift carries correctly into the next decade.
   always_comb begin
      bcd_adj = bcd_wr;
      for (int i = 0; i < 4; i++) begin
         if (bcd_wr[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_wr[4*i +: 4] + 4'd3;
      end
      bcd_nxt = {bcd_adj[14:0], bin_sr[13]};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         bin_sr  <= '0;
         bcd_wr  <= '0;
         cnt     <= '0;
         big     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd_out <= '0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bin_sr <= bin_in;
                  bcd_wr <= '0;
                  cnt    <= '0;
                  big    <= (bin_in > 14'd9999);
                  busy   <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               bcd_wr <= bcd_nxt;
               bin_sr <= {bin_sr[12:0], 1'b0};
               if (cnt == 4'd13) begin
                  // Out-of-range inputs overflow the 4-digit working register; publish the saturated value instead.
                  bcd_out <= big ? 16'h9999 : bcd_nxt;
                  ovf     <= big;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against an arithmetic decimal-digit reference.
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [13:0] bin_in;
   logic        busy;
   logic        done;
   logic [15:0] bcd_out;
   logic        ovf;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int dbl = 0;
   int exp_dones = 0;
   logic prev_done = 1'b0;

   bin2bcd_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out),
      .ovf     (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         if (prev_done) dbl++;
      end
      prev_done = (done === 1'b1);
   end

   function automatic logic [15:0] ref_bcd(input int v);
      if (v > 9999) return 16'h9999;
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (done !== 1'b1 && lat < 40);
   endtask

   task automatic do_conv(input int v);
      int lat;
      start  = 1'b1;
      bin_in = 14'(v);
      tick();
      start  = 1'b0;
      bin_in = 14'($urandom_range(0, 16383));
      check("busy_after_start", 32'(busy), 32'd1);
      wait_done(lat);
      exp_dones++;
      check("latency", lat, 14);
      check("bcd_out", 32'(bcd_out), 32'(ref_bcd(v)));
      check("ovf", 32'(ovf), (v > 9999) ? 32'd1 : 32'd0);
      tick();
      check("done_single", 32'(done), 32'd0);
   endtask

   initial begin
      int lat;
      int bnd[14];
      int vals[301];
      rst    = 1'b0;
      start  = 1'b0;
      bin_in = '0;
      bnd = '{0, 1, 9, 10, 99, 100, 999, 1000, 4095, 9998, 9999, 10000, 10001, 16383};

      // Reset state, with start asserted to show reset has priority.
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bcd", 32'(bcd_out), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);

      // First start on the first edge with reset released.
      rst = 1'b1;
      do_conv(0);
      do_conv(1234);
      do_conv(9999);
      do_conv(10000);
      do_conv(16383);
      for (int i = 0; i < 14; i++) do_conv(bnd[i]);

      // start held high; bin_in changes after capture; re-accept on the done cycle.
      start  = 1'b1;
      bin_in = 14'd507;
      tick();
      bin_in = 14'd42;
      wait_done(lat);
      exp_dones++;
      check("held_lat", lat, 14);
      check("held_bcd", 32'(bcd_out), 32'h0507);
      tick();
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_done_low", 32'(done), 32'd0);
      repeat (4) tick();
      start = 1'b0;
      wait_done(lat);
      exp_dones++;
      check("b2b_lat", lat, 10);
      check("b2b_bcd", 32'(bcd_out), 32'h0042);
      repeat (20) tick();
      check("held_idle", 32'(busy), 32'd0);
      check("held_done_cnt", done_cnt, exp_dones);

      // Reset during iteration 7 aborts the conversion.
      start  = 1'b1;
      bin_in = 14'd4321;
      tick();
      start = 1'b0;
      repeat (6) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_bcd", 32'(bcd_out), 32'h0000);
      check("abort_ovf", 32'(ovf), 32'd0);
      repeat (20) tick();
      check("abort_no_done", done_cnt, exp_dones);
      check("abort_bcd_hold", 32'(bcd_out), 32'h0000);
      do_conv(8765);

      // Random back-to-back stream with start held high.
      for (int i = 0; i < 301; i++) vals[i] = int'($urandom_range(0, 16383));
      start  = 1'b1;
      bin_in = 14'(vals[0]);
      tick();
      bin_in = 14'(vals[1]);
      for (int k = 0; k < 300; k++) begin
         wait_done(lat);
         exp_dones++;
         check("rnd_lat", lat, 14);
         check("rnd_bcd", 32'(bcd_out), 32'(ref_bcd(vals[k])));
         check("rnd_ovf", 32'(ovf), (vals[k] > 9999) ? 32'd1 : 32'd0);
         if (k < 299) begin
            tick();
            bin_in = 14'(vals[k+2]);
         end
      end
      start = 1'b0;
      repeat (3) tick();

      check("done_count", done_cnt, exp_dones);
      check("done_never_double", dbl, 0);
      check("final_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
